// File: rtl/whack_pkg.sv
// Shared constants and helpers for the button front end.
package whack_pkg;

   localparam int N_BTN_DEF        = 8;
   localparam int DEBOUNCE_DEF     = 5000;

   // Counter width able to hold 0..cycles-1 (at least one bit).
   function automatic int cnt_width(input int cycles);
      int w;
      w = 1;
      while ((1 << w) < cycles) w++;
      return w;
   endfunction

endpackage

// File: rtl/debounce_chan.sv
// One button channel: 2-flop synchronizer, debounce counter, level, press pulse.
module debounce_chan
   import whack_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEF,
   parameter int CW              = cnt_width(DEBOUNCE_CYCLES)
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw_i,
   output logic level_o,
   output logic press_o
);

   logic          sync1_q, sync2_q;
   logic          level_q, level_d;
   logic          press_q, press_d;
   logic [CW-1:0] cnt_q, cnt_d;

   // Bring the asynchronous button into the clock domain before anything looks at it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
      end else begin
         sync1_q <= raw_i;
         sync2_q <= sync1_q;
      end
   end

   // Count consecutive cycles of disagreement; flip the level once the window is full.
   // The counter saturates at the flip point, so it can never wrap.
   always_comb begin
      cnt_d   = '0;
      level_d = level_q;
      press_d = 1'b0;
      if (sync2_q != level_q) begin
         if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
            level_d = ~level_q;
            press_d = ~level_q;   // pulse only on the 0->1 flip
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   // Debounce state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q   <= '0;
         level_q <= 1'b0;
         press_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         level_q <= level_d;
         press_q <= press_d;
      end
   end

   assign level_o = level_q;
   assign press_o = press_q;

endmodule

// File: rtl/btn_conditioner.sv
// Debounces N_BTN buttons and summarises the press pulses for the game logic.
module btn_conditioner
   import whack_pkg::*;
#(
   parameter int N_BTN           = N_BTN_DEF,
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_BTN-1:0] btn_raw,
   output logic [N_BTN-1:0] btn_level,
   output logic [N_BTN-1:0] btn_press,
   output logic             press_valid,
   output logic [2:0]       press_idx,
   output logic             multi_press
);

   localparam int CW = cnt_width(DEBOUNCE_CYCLES);

   for (genvar g = 0; g < N_BTN; g++) begin : g_chan
      debounce_chan #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .CW              (CW)
      ) u_chan (
         .clk     (clk),
         .rst_n   (rst_n),
         .raw_i   (btn_raw[g]),
         .level_o (btn_level[g]),
         .press_o (btn_press[g])
      );
   end

   // Lowest-numbered pressed channel wins the index; scan high to low so low overrides.
   always_comb begin
      press_idx = 3'd0;
      for (int i = N_BTN - 1; i >= 0; i--) begin
         if (btn_press[i]) press_idx = 3'(i);
      end
   end

   // More than one pulse in the same cycle.
   always_comb begin
      int pc;
      pc = 0;
      for (int i = 0; i < N_BTN; i++) begin
         if (btn_press[i]) pc++;
      end
      multi_press = (pc > 1);
   end

   assign press_valid = |btn_press;

endmodule

// File: doc/btn_conditioner.md
BTN_CONDITIONER -- requirements
Module: btn_conditioner

Interface
REQ-001 SHALL have parameter N_BTN, default 8, number of button channels.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 5000, stable-input window in clk cycles (5 ms at 1 MHz); legal range 2..65535.
REQ-003 SHALL have port clk, input, 1, single system clock (1 MHz nominal).
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port btn_raw, input, N_BTN, asynchronous mechanical button inputs, active-high.
REQ-006 SHALL have port btn_level, output, N_BTN, debounced button level per channel.
REQ-007 SHALL have port btn_press, output, N_BTN, one-cycle pulse per channel on debounced rising edge; drives whack_a_mole btn.
REQ-008 SHALL have port press_valid, output, 1, high in any cycle where btn_press is nonzero.
REQ-009 SHALL have port press_idx, output, 3, index of lowest-numbered bit set in btn_press; 0 when press_valid low.
REQ-010 SHALL have port multi_press, output, 1, high when more than one btn_press bit is set in the same cycle.

Function
REQ-011 SHALL pass each btn_raw bit through a two-flop synchronizer before any other use.
REQ-012 SHALL keep one debounce counter per channel, width ceil(log2(DEBOUNCE_CYCLES)).
REQ-013 SHALL clear a channel counter in any cycle where its synchronized bit equals btn_level.
REQ-014 SHALL increment the counter while the synchronized bit differs from btn_level.
REQ-015 SHALL toggle btn_level and clear the counter on the edge where the counter equals DEBOUNCE_CYCLES-1 and the bit still differs.
REQ-016 SHALL give fixed latency: raw bit changed before edge k and held -> btn_level changes at edge k+1+DEBOUNCE_CYCLES.
REQ-017 SHALL ignore any raw pulse or glitch shorter than DEBOUNCE_CYCLES synchronized cycles: no btn_level change, no btn_press.
REQ-018 SHALL assert btn_press[i] for exactly one cycle, registered, in the same cycle btn_level[i] goes 0->1; never on 1->0.
REQ-019 SHALL derive press_valid, press_idx and multi_press combinationally from the registered btn_press.
REQ-020 SHALL treat channels fully independently; simultaneous presses produce simultaneous pulses, with no arbitration or dropping.
REQ-021 SHALL NOT re-pulse a held button; the next pulse requires a debounced release followed by a debounced press.
REQ-022 SHALL avoid counter wrap: the counter never exceeds DEBOUNCE_CYCLES-1.

Reset
REQ-023 SHALL asynchronously clear synchronizer flops, counters, btn_level and btn_press on rst_n low.
REQ-024 SHALL then hold press_valid=0, press_idx=0 and multi_press=0.
REQ-025 SHALL NOT emit a btn_press after reset release for a button already held during reset until the full debounce window elapses; exactly one pulse is emitted at that point.
REQ-026 SHALL abort an in-progress count on reset mid-debounce with no pulse; counting restarts from zero.

Structure
REQ-027 SHALL place N_BTN default, DEBOUNCE_CYCLES default and the counter-width function in shared package whack_pkg.
REQ-028 SHALL implement one per-channel sub-module, debounce_chan (synchronizer, counter, level, press pulse), instantiated N_BTN times with generate.
REQ-029 SHALL keep the top-level-only logic to the priority encoder and the multi_press popcount>1 check.

Verification (bench uses DEBOUNCE_CYCLES=4)
REQ-030 SHALL verify clean press: btn_raw[2] 0->1 before edge 10 and held -> btn_level[2]=1 and btn_press=8'h04 at edge 15 only; press_valid=1 and press_idx=2 for that cycle.
REQ-031 SHALL verify glitch rejection: btn_raw[0] high for 3 cycles then low -> btn_level and btn_press stay 0 throughout.
REQ-032 SHALL verify bounce: btn_raw[5] toggles 1,0,1,0,1 on consecutive cycles then holds 1 -> exactly one btn_press[5] pulse, 1+4 cycles after the final rising sample.
REQ-033 SHALL verify simultaneous press: btn_raw 8'h81 asserted together -> btn_press=8'h81 for one cycle, press_idx=0, multi_press=1.
REQ-034 SHALL verify hold and release: held 100 cycles -> one pulse; release -> btn_level falls after 5 cycles with no pulse; re-press -> second pulse.
REQ-035 SHALL verify reset mid-count: rst_n low 2 cycles while the counter is at 2 -> all outputs 0; input still held -> pulse 5 cycles after reset release.
